// File: rtl/mc_control_unit_pkg.sv
// mc_control_unit_pkg: shared CPU encodings for the multi-cycle MIPS control path.
// ALU op codes, opcode/funct constants, datapath select codes and FSM state encoding.
package mc_control_unit_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_REG   = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_WB_MEM   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_WB_I     = 4'd11
    } state_t;

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: opcode/funct -> ALU op code plus legality flags.
// Logic immediates (andi/ori/xori) are accepted only when MC_CTRL_IMM_LOGIC_EN is defined.
module mc_alu_decode
    import mc_control_unit_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] aluOp,
    output logic       opLegal,
    output logic       functLegal,
    output logic       extZero
);

    logic [3:0] functOp;
    logic [3:0] immOp;

    always_comb begin
        functOp = ALU_ADD;
        functLegal = 1'b1;
        case (funct)
            FN_ADD: functOp = ALU_ADD;
            FN_SUB: functOp = ALU_SUB;
            FN_AND: functOp = ALU_AND;
            FN_OR:  functOp = ALU_OR;
            FN_XOR: functOp = ALU_XOR;
            FN_NOR: functOp = ALU_NOR;
            FN_SLT: functOp = ALU_SLT;
            FN_SLL: functOp = ALU_SLL;
            default: functLegal = 1'b0;
        endcase
        immOp = ALU_ADD;
        opLegal = 1'b1;
        extZero = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ;
`ifdef MC_CTRL_IMM_LOGIC_EN
            OP_ANDI: begin immOp = ALU_AND; extZero = 1'b1; end
            OP_ORI:  begin immOp = ALU_OR;  extZero = 1'b1; end
            OP_XORI: begin immOp = ALU_XOR; extZero = 1'b1; end
`endif
            default: opLegal = 1'b0;
        endcase
        aluOp = (opcode == OP_RTYPE) ? functOp : immOp;
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS control FSM (fetch/decode/execute/mem/writeback).
// Optional logic-immediate support via `MC_CTRL_IMM_LOGIC_EN.
module mc_control_unit
    import mc_control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic [3:0] aluOp,
    output logic       extZero,
    output logic       illegal,
    output logic       retired
);

    state_t state, nextState;
    logic [3:0] decAluOp;
    logic opLegal, functLegal, decExtZero;

    mc_alu_decode uDecode (
        .opcode     (opcode),
        .funct      (funct),
        .aluOp      (decAluOp),
        .opLegal    (opLegal),
        .functLegal (functLegal),
        .extZero    (decExtZero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else state <= nextState;
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    always_comb begin
        nextState = state;
        pcWrite = 1'b0;
        pcWriteCond = 1'b0;
        iorD = 1'b0;
        memRead = 1'b0;
        memWrite = 1'b0;
        irWrite = 1'b0;
        memToReg = 1'b0;
        regDst = 1'b0;
        regWrite = 1'b0;
        aluSrcA = SRCA_PC;
        aluSrcB = SRCB_REG;
        pcSource = PCSRC_ALU;
        aluOp = ALU_ADD;
        extZero = 1'b0;
        illegal = 1'b0;
        retired = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = SRCB_FOUR;
                    irWrite = memReady;
                    pcWrite = memReady;
                    nextState = memReady ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    aluSrcB = SRCB_IMM_SH2;
                    illegal = !opLegal;
                    nextState = (opcode == OP_RTYPE) ? S_EXEC_R :
                                (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                                (opcode == OP_BEQ) ? S_BRANCH :
                                (opcode == OP_J) ? S_JUMP :
                                opLegal ? S_EXEC_I : S_FETCH;
                end
                S_EXEC_R: begin
                    aluSrcA = (funct == FN_SLL) ? SRCA_SHAMT : SRCA_REG;
                    aluOp = decAluOp;
                    illegal = !functLegal;
                    nextState = functLegal ? S_WB_R : S_FETCH;
                end
                S_WB_R: begin
                    regDst = 1'b1;
                    regWrite = 1'b1;
                    retired = 1'b1;
                    nextState = S_FETCH;
                end
                S_MEM_ADDR: begin
                    aluSrcA = SRCA_REG;
                    aluSrcB = SRCB_IMM;
                    nextState = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    memRead = 1'b1;
                    iorD = 1'b1;
                    nextState = memReady ? S_WB_MEM : S_MEM_RD;
                end
                S_WB_MEM: begin
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                    retired = 1'b1;
                    nextState = S_FETCH;
                end
                S_MEM_WR: begin
                    memWrite = 1'b1;
                    iorD = 1'b1;
                    retired = memReady;
                    nextState = memReady ? S_FETCH : S_MEM_WR;
                end
                S_BRANCH: begin
                    aluSrcA = SRCA_REG;
                    aluOp = ALU_SUB;
                    pcWriteCond = 1'b1;
                    pcWrite = zero;
                    pcSource = PCSRC_ALUOUT;
                    retired = 1'b1;
                    nextState = S_FETCH;
                end
                S_JUMP: begin
                    pcWrite = 1'b1;
                    pcSource = PCSRC_JUMP;
                    retired = 1'b1;
                    nextState = S_FETCH;
                end
                S_EXEC_I: begin
                    aluSrcA = SRCA_REG;
                    aluSrcB = SRCB_IMM;
                    aluOp = decAluOp;
                    extZero = decExtZero;
                    nextState = S_WB_I;
                end
                S_WB_I: begin
                    regWrite = 1'b1;
                    retired = 1'b1;
                    nextState = S_FETCH;
                end
                default: nextState = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized instruction stream against a per-instruction outcome model.
// A reactive memory supplies memReady; a monitor scores each retire/illegal against a queue.
module tb_mc_control_unit;
    import mc_control_unit_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [5:0] opcode = 6'h3F, funct = 6'h00;
    logic zero = 1'b0, memReady = 1'b0;
    logic pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite;
    logic [1:0] aluSrcA, aluSrcB, pcSource;
    logic [3:0] aluOp;
    logic extZero, illegal, retired;
    logic [21:0] allOuts;

    mc_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
        .aluOp(aluOp), .extZero(extZero), .illegal(illegal), .retired(retired)
    );

    assign allOuts = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                      regWrite, aluSrcA, aluSrcB, pcSource, aluOp, extZero, illegal, retired};

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit ill;
        int cyc, rw, mwc, mrd, fch, pcw;
        bit rd, m2r, chkOp, ez;
        logic [3:0] op;
        logic [1:0] srcA;
    } exp_t;

    exp_t expQ[$];
    int lat[$];
    bit monOn = 1'b0;
    int checks = 0, failures = 0;

    logic [5:0] fnTab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
    logic [3:0] fnOp  [8] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLL};
    logic [5:0] badFn [3] = '{6'h01, 6'h21, 6'h3F};
    logic [5:0] badOp [3] = '{6'h3F, 6'h01, 6'h05};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Memory answers each new access after a latency popped from lat; outside accesses memReady is noise.
    initial begin : memory
        int cnt;
        bit busy;
        cnt = 0;
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                busy = 1'b0;
                memReady = 1'b0;
            end else if (memRead || memWrite) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = (lat.size() > 0) ? lat.pop_front() : 0;
                end
                memReady = (cnt == 0);
                if (cnt == 0) busy = 1'b0;
                else cnt--;
            end else memReady = 1'($urandom_range(0, 1));
        end
    end

    initial begin : monitor
        int cyc, rw, mwc, mrd, fch, pcw, irw;
        bit rd, m2r, ez, clr;
        logic [3:0] op;
        logic [1:0] sa;
        exp_t e;
        clr = 1'b1;
        forever begin
            @(negedge clk);
            if (clr || !monOn || !rst_n) begin
                cyc = 0; rw = 0; mwc = 0; mrd = 0; fch = 0; pcw = 0; irw = 0;
                rd = 0; m2r = 0; ez = 0; op = 'x; sa = 'x; clr = 1'b0;
            end
            if (monOn && rst_n) begin
                cyc++;
                if (regWrite) begin rw++; rd = regDst; m2r = memToReg; end
                if (memWrite) mwc++;
                if (memRead && iorD) mrd++;
                if (memRead && !iorD) fch++;
                if (pcWrite) pcw++;
                if (irWrite) irw = cyc;
                if (irw > 0 && cyc == irw + 2) begin op = aluOp; sa = aluSrcA; ez = extZero; end
                if (retired || illegal) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_completion: got illegal=%0d retired=%0d expected none", illegal, retired);
                    end else begin
                        e = expQ.pop_front();
                        chk({e.name, "_illegal"}, illegal, e.ill);
                        chk({e.name, "_retired"}, retired, !e.ill);
                        chk({e.name, "_cycles"}, cyc, e.cyc);
                        chk({e.name, "_regWrites"}, rw, e.rw);
                        if (e.rw > 0) begin
                            chk({e.name, "_regDst"}, rd, e.rd);
                            chk({e.name, "_memToReg"}, m2r, e.m2r);
                        end
                        chk({e.name, "_memWriteCycles"}, mwc, e.mwc);
                        chk({e.name, "_dataReadCycles"}, mrd, e.mrd);
                        chk({e.name, "_fetchCycles"}, fch, e.fch);
                        chk({e.name, "_pcWrites"}, pcw, e.pcw);
                        if (e.chkOp) begin
                            chk({e.name, "_aluOp"}, op, e.op);
                            chk({e.name, "_aluSrcA"}, sa, e.srcA);
                            chk({e.name, "_extZero"}, ez, e.ez);
                        end
                    end
                    clr = 1'b1;
                end
            end
        end
    end

    // Called one step after the rising edge that starts the instruction's FETCH.
    task automatic issue(input int kind, input int sel, input int fw, input int mw, input bit z);
        exp_t e;
        bit done;
        e.name = "?"; e.ill = 0; e.cyc = 0; e.rw = 0; e.mwc = 0; e.mrd = 0;
        e.fch = 1 + fw; e.pcw = 1; e.rd = 0; e.m2r = 0; e.chkOp = 0; e.ez = 0;
        e.op = ALU_ADD; e.srcA = 2'd1;
        funct = 6'($urandom);
        zero = 1'($urandom_range(0, 1));
        lat.push_back(fw);
        case (kind)
            0: begin
                e.name = "rtype"; opcode = 6'h00; funct = fnTab[sel % 8];
                e.cyc = 4 + fw; e.rw = 1; e.rd = 1; e.chkOp = 1;
                e.op = fnOp[sel % 8]; e.srcA = (sel % 8 == 7) ? 2'd2 : 2'd1;
            end
            1: begin
                e.name = "bad_funct"; opcode = 6'h00; funct = badFn[sel % 3];
                e.ill = 1; e.cyc = 3 + fw;
            end
            2: begin
                e.name = "lw"; opcode = 6'h23; lat.push_back(mw);
                e.cyc = 5 + fw + mw; e.rw = 1; e.m2r = 1; e.mrd = 1 + mw; e.chkOp = 1;
            end
            3: begin
                e.name = "sw"; opcode = 6'h2B; lat.push_back(mw);
                e.cyc = 4 + fw + mw; e.mwc = 1 + mw; e.chkOp = 1;
            end
            4: begin
                e.name = "beq"; opcode = 6'h04; zero = z;
                e.cyc = 3 + fw; e.pcw = 1 + int'(z); e.chkOp = 1; e.op = ALU_SUB;
            end
            5: begin
                e.name = "j"; opcode = 6'h02; e.cyc = 3 + fw; e.pcw = 2;
            end
            6: begin
                e.name = "addi"; opcode = 6'h08; e.cyc = 4 + fw; e.rw = 1; e.chkOp = 1;
            end
            7: begin
                e.name = "logic_imm"; opcode = 6'(6'h0C + sel % 3);
`ifdef MC_CTRL_IMM_LOGIC_EN
                e.cyc = 4 + fw; e.rw = 1; e.chkOp = 1; e.ez = 1;
                e.op = (sel % 3 == 0) ? ALU_AND : (sel % 3 == 1) ? ALU_OR : ALU_XOR;
`else
                e.ill = 1; e.cyc = 2 + fw;
`endif
            end
            default: begin
                e.name = "bad_opcode"; opcode = badOp[sel % 3]; e.ill = 1; e.cyc = 2 + fw;
            end
        endcase
        expQ.push_back(e);
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = retired || illegal;
        end
        chk({e.name, "_completes"}, done, 1'b1);
        if (!done) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "instruction did not complete");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        bit wentLow;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_all_outputs_zero", allOuts, 22'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_memRead", memRead, 1'b1);
        chk("post_reset_iorD", iorD, 1'b0);
        chk("post_reset_aluOp", aluOp, ALU_ADD);
        chk("post_reset_aluSrcB", aluSrcB, 2'd1);
        chk("post_reset_irWrite", irWrite, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        monOn = 1'b1;
        issue(0, 0, 0, 0, 0);
        issue(2, 0, 0, 3, 0);
        issue(4, 0, 0, 0, 1);
        issue(4, 0, 0, 0, 0);
        issue(8, 0, 0, 0, 0);
        issue(1, 0, 0, 0, 0);
        issue(7, 1, 0, 0, 0);
        issue(3, 0, 2, 1, 0);
        for (int i = 0; i < 200; i++)
            issue($urandom_range(0, 8), $urandom_range(0, 7),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                  1'($urandom_range(0, 1)));
        monOn = 1'b0;
        chk("scoreboard_drained", expQ.size(), 0);
        opcode = 6'h2B;
        lat.push_back(0);
        lat.push_back(6);
        wentLow = 1'b0;
        for (int k = 0; k < 20 && !wentLow; k++) begin
            @(negedge clk);
            wentLow = memWrite;
        end
        chk("sw_reaches_mem_wr", wentLow, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_abort_memWrite", memWrite, 1'b0);
        chk("async_abort_outputs", allOuts, 22'd0);
        lat.delete();
        @(posedge clk);
        #1;
        opcode = 6'h3F;
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_fetch_memRead", memRead, 1'b1);
        chk("restart_no_write_c1", {regWrite, memWrite}, 2'b00);
        @(negedge clk);
        chk("restart_no_write_c2", {regWrite, memWrite}, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
